dmem_param: RTL and testbench
=============================

DMEM_PARAM -- requirements
Module: dmem_param

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset inputs SHALL exist.
REQ-002 Parameter DATAW, default 32, SHALL set the data word width in bits; it SHALL be a multiple of 8.
REQ-003 Parameter ADDRW, default 16, SHALL set the word-address width.
REQ-004 Parameter DEPTH, default 65536, SHALL set the number of implemented words; DEPTH SHALL satisfy 2 <= DEPTH <= 2**ADDRW.
REQ-005 Port clk, input, width 1, SHALL be the clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, width 1, SHALL be the asynchronous active-high reset.
REQ-007 Port req_valid, input, width 1, SHALL mark a valid request.
REQ-008 Port req_ready, output, width 1, SHALL mark that the block accepts a request this cycle.
REQ-009 Port req_wr, input, width 1, SHALL select the operation: 1 = write, 0 = read.
REQ-010 Port req_addr, input, width ADDRW, SHALL carry the word address.
REQ-011 Port req_wdata, input, width DATAW, SHALL carry the write data.
REQ-012 Port req_be, input, width DATAW/8, SHALL carry the write byte enables; bit i SHALL cover data bits [8i+7:8i].
REQ-013 Port rsp_valid, output, width 1, SHALL mark a valid read response.
REQ-014 Port rsp_ready, input, width 1, SHALL mark that the consumer accepts the response.
REQ-015 Port rsp_rdata, output, width DATAW, SHALL carry the read data.
REQ-016 Port rsp_err, output, width 1, SHALL flag a read response for an out-of-range address.
REQ-017 Port busy, output, width 1, SHALL be high while initialisation is in progress.
REQ-018 Port oob_flag, output, width 1, SHALL be a sticky flag for a dropped out-of-range write.

Function
REQ-019 The FSM SHALL have two states, INIT and RUN; on reset it SHALL enter INIT with clear pointer 0.
REQ-020 In INIT, the FSM SHALL write zero to mem[clear pointer] on each cycle and then increment the pointer.
REQ-021 After the cycle that writes word DEPTH-1, the FSM SHALL move to RUN; INIT SHALL last exactly DEPTH cycles.
REQ-022 busy SHALL be 1 in INIT and 0 in RUN.
REQ-023 req_ready SHALL equal (state == RUN) && (!rsp_valid || rsp_ready).
REQ-024 A request SHALL be accepted only on a cycle where req_valid && req_ready; request inputs SHALL be ignored on all other cycles.
REQ-025 An accepted write with req_addr < DEPTH SHALL update, at that edge, only the byte lanes whose req_be bit is 1.
REQ-026 An accepted write SHALL produce no response.
REQ-027 An accepted write with req_be = 0 SHALL leave memory unchanged.
REQ-028 An accepted write with req_addr >= DEPTH SHALL leave memory unchanged and set oob_flag to 1.
REQ-029 oob_flag SHALL be cleared only by reset.
REQ-030 An accepted read SHALL assert rsp_valid on the next cycle (latency 1).
REQ-031 For a read with req_addr < DEPTH, rsp_rdata SHALL hold mem[req_addr] as of the acceptance edge, and rsp_err SHALL be 0.
REQ-032 For a read with req_addr >= DEPTH, rsp_rdata SHALL be 0 and rsp_err SHALL be 1.
REQ-033 A read accepted on the cycle after a write to the same address SHALL return the newly written data.
REQ-034 While rsp_valid && !rsp_ready, rsp_valid, rsp_rdata and rsp_err SHALL hold stable, and no new request SHALL be accepted.
REQ-035 rsp_valid SHALL deassert after a handshake (rsp_valid && rsp_ready) unless a new read is accepted in the same cycle.
REQ-036 Back-to-back reads with rsp_ready held at 1 SHALL sustain one response per cycle.

Reset
REQ-037 On rst, asynchronously: state = INIT, clear pointer = 0, busy = 1, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, oob_flag = 0.
REQ-038 A reset asserted mid-INIT or mid-RUN SHALL abort all activity, drop any pending response, and restart INIT from word 0.
REQ-039 After reset, every implemented word SHALL read as 0.

Verification (DATAW=32, ADDRW=4, DEPTH=12)
REQ-040 Release reset -> busy = 1 for exactly 12 cycles and req_ready = 0 throughout; then busy = 0 and req_ready = 1; a read of address 11 -> rsp_rdata = 0x00000000.
REQ-041 Write addr 3, data 0xAABBCCDD, be 1111; then write addr 3, data 0x11223344, be 0101; then read addr 3 -> rsp_rdata = 0xAA22CC44, rsp_err = 0.
REQ-042 Write addr 13, data 0xFFFFFFFF -> oob_flag = 1 and memory unchanged; read addr 14 -> rsp_rdata = 0, rsp_err = 1.
REQ-043 Read addr 3 with rsp_ready = 0 for 3 cycles -> rsp_valid and rsp_rdata stable and req_ready = 0 for those 3 cycles; raise rsp_ready -> handshake completes and the next read is accepted that cycle.
REQ-044 Assert rst while busy, at clear pointer 5, after addr 3 was previously written with nonzero data -> response dropped and INIT restarts; after 12 more cycles, a read of addr 3 -> 0x00000000 and oob_flag = 0.
REQ-045 Issue 4 back-to-back reads at addrs 0..3 with rsp_ready = 1 -> 4 consecutive rsp_valid cycles, in order, starting 1 cycle after the first accept.

Source files
------------

// File: rtl/dmem_param.sv
// Parameterised word-addressed data memory with byte-enabled writes, a one-deep response
// register, and a self-clearing INIT phase that zeroes every implemented word after reset.
module dmem_param #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned ADDRW = 16,
  parameter int unsigned DEPTH = 65536
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_wr,
  input  logic [ADDRW-1:0]   req_addr,
  input  logic [DATAW-1:0]   req_wdata,
  input  logic [DATAW/8-1:0] req_be,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATAW-1:0]   rsp_rdata,
  output logic               rsp_err,
  output logic               busy,
  output logic               oob_flag
);

  localparam int unsigned NBYTES = DATAW / 8;
  localparam logic [ADDRW-1:0] LAST = ADDRW'(DEPTH - 1);

  if ((DATAW % 8) != 0 || DEPTH < 2 || DEPTH > (2 ** ADDRW)) begin : g_bad_params
    $error("dmem_param: illegal DATAW/ADDRW/DEPTH combination");
  end

  typedef enum logic {StInit, StRun} state_e;

  state_e           state_q;
  logic [ADDRW-1:0] clr_ptr_q;
  logic [DATAW-1:0] mem [DEPTH];

  logic in_range;
  logic accept;
  logic rd_accept;
  logic wr_accept;

  // Zero-extend by one bit so DEPTH == 2**ADDRW still compares correctly.
  assign in_range  = {1'b0, req_addr} < (ADDRW + 1)'(DEPTH);
  assign req_ready = (state_q == StRun) && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_wr;
  assign wr_accept = accept && req_wr;
  assign busy      = (state_q == StInit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StInit;
      clr_ptr_q <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      oob_flag  <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (clr_ptr_q == LAST) state_q <= StRun;
          clr_ptr_q <= clr_ptr_q + 1'b1;
        end
        StRun: begin
          if (rd_accept) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= in_range ? mem[req_addr] : '0;
            rsp_err   <= !in_range;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
          if (wr_accept && !in_range) oob_flag <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset of its own; INIT sweeps it to zero instead.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_accept && in_range) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_param.sv
// Directed bench for dmem_param with DATAW=32, ADDRW=4, DEPTH=12.
module tb_dmem_param;

  localparam int DATAW = 32;
  localparam int ADDRW = 4;
  localparam int DEPTH = 12;

  logic               clk;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic               req_wr;
  logic [ADDRW-1:0]   req_addr;
  logic [DATAW-1:0]   req_wdata;
  logic [DATAW/8-1:0] req_be;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATAW-1:0]   rsp_rdata;
  logic               rsp_err;
  logic               busy;
  logic               oob_flag;

  int checks;
  int failures;

  dmem_param #(
    .DATAW(DATAW),
    .ADDRW(ADDRW),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .oob_flag (oob_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; the request is presented for exactly one posedge.
  task automatic do_req(input logic wr, input logic [ADDRW-1:0] addr,
                        input logic [DATAW-1:0] wdata, input logic [DATAW/8-1:0] be);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(negedge clk);
    req_valid = 1'b0;
    req_wr    = 1'b0;
  endtask

  // Called at the negedge where reset was just released.
  task automatic wait_init(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check({tag, "_busy_hi"}, 32'(busy), 32'd1);
      check({tag, "_ready_lo"}, 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    #1;
    check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check({tag, "_ready_hi"}, 32'(req_ready), 32'd1);
  endtask

  logic [31:0] bb_exp [4];

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;
    bb_exp    = '{32'h0000_0010, 32'h0000_0011, 32'h0000_0012, 32'hAA22_CC44};

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_oob", 32'(oob_flag), 32'd0);

    rst = 1'b0;
    wait_init("init1");

    // Top implemented word reads back zero.
    do_req(1'b0, 4'd11, '0, '0);
    check("rd11_valid", 32'(rsp_valid), 32'd1);
    check("rd11_data", rsp_rdata, 32'd0);
    check("rd11_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    check("rd11_drop", 32'(rsp_valid), 32'd0);

    // Byte-enable merge, then read immediately after the last write.
    do_req(1'b1, 4'd3, 32'hAABB_CCDD, 4'b1111);
    check("wr_no_rsp", 32'(rsp_valid), 32'd0);
    do_req(1'b1, 4'd3, 32'h1122_3344, 4'b0101);
    do_req(1'b0, 4'd3, '0, '0);
    check("merge_valid", 32'(rsp_valid), 32'd1);
    check("merge_data", rsp_rdata, 32'hAA22_CC44);
    check("merge_err", 32'(rsp_err), 32'd0);

    // Zero byte-enable write is a no-op.
    do_req(1'b1, 4'd3, 32'hFFFF_FFFF, 4'b0000);
    do_req(1'b0, 4'd3, '0, '0);
    check("be0_data", rsp_rdata, 32'hAA22_CC44);

    // Out-of-range write and read.
    check("oob_before", 32'(oob_flag), 32'd0);
    do_req(1'b1, 4'd13, 32'hFFFF_FFFF, 4'b1111);
    check("oob_set", 32'(oob_flag), 32'd1);
    check("oob_no_rsp", 32'(rsp_valid), 32'd0);
    do_req(1'b0, 4'd14, '0, '0);
    check("oob_rd_valid", 32'(rsp_valid), 32'd1);
    check("oob_rd_data", rsp_rdata, 32'd0);
    check("oob_rd_err", 32'(rsp_err), 32'd1);
    do_req(1'b0, 4'd3, '0, '0);
    check("oob_mem_keep", rsp_rdata, 32'hAA22_CC44);
    check("oob_sticky", 32'(oob_flag), 32'd1);

    // Backpressure: hold the response for three cycles with a new read waiting.
    rsp_ready = 1'b0;
    do_req(1'b0, 4'd3, '0, '0);
    req_valid = 1'b1;
    req_addr  = 4'd11;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", rsp_rdata, 32'hAA22_CC44);
      check("stall_ready", 32'(req_ready), 32'd0);
      if (i < 2) @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("next_valid", 32'(rsp_valid), 32'd1);
    check("next_data", rsp_rdata, 32'd0);
    @(negedge clk);
    check("next_drop", 32'(rsp_valid), 32'd0);

    // Back-to-back reads of addresses 0..3.
    do_req(1'b1, 4'd0, 32'h0000_0010, 4'b1111);
    do_req(1'b1, 4'd1, 32'h0000_0011, 4'b1111);
    do_req(1'b1, 4'd2, 32'h0000_0012, 4'b1111);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 4'(i);
      @(negedge clk);
      check("b2b_valid", 32'(rsp_valid), 32'd1);
      check("b2b_data", rsp_rdata, bb_exp[i]);
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_end", 32'(rsp_valid), 32'd0);

    // Reset in RUN with a pending response.
    rsp_ready = 1'b0;
    do_req(1'b0, 4'd3, '0, '0);
    check("pend_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(rsp_valid), 32'd0);
    check("arst_data", rsp_rdata, 32'd0);
    check("arst_busy", 32'(busy), 32'd1);
    check("arst_oob", 32'(oob_flag), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;

    // Reset again partway through INIT, at clear pointer 5.
    repeat (5) @(negedge clk);
    check("mid_init_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_init("init2");
    check("init2_oob", 32'(oob_flag), 32'd0);

    // Every implemented word reads zero after the restarted INIT.
    req_valid = 1'b1;
    req_wr    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      req_addr = 4'(i);
      @(negedge clk);
      check("clr_valid", 32'(rsp_valid), 32'd1);
      check("clr_data", rsp_rdata, 32'd0);
      check("clr_err", 32'(rsp_err), 32'd0);
    end
    req_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
